pipeline_perf_counter: RTL and testbench

//  Performance-event counter that sits beside the hazard-detection and control units of the 5-stage CPU.

---
 rtl/pipeline_perf_counter_if.sv | 31 +++
 rtl/pipeline_perf_counter.sv | 94 +++++++++
 tb/tb_pipeline_perf_counter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_perf_counter_if.sv
// Event sampling and shadow-readout bundle between the CPU hazard/control units and the perf counter.
// The master drives events and read requests; the slave returns readout data and run status.
interface pipeline_perf_counter_if #(
   parameter int CNT_W = 32
);
   logic             start_i;
   logic             stall_i;
   logic             jump_i;
   logic             branch_i;
   logic [1:0]       flush_i;
   logic             wb_valid_i;
   logic             snap_i;
   logic             rd_en_i;
   logic [1:0]       rd_sel_i;
   logic [CNT_W-1:0] rd_data_o;
   logic             rd_valid_o;
   logic             running_o;
   logic             done_o;

   modport master (
      output start_i, stall_i, jump_i, branch_i, flush_i, wb_valid_i,
             snap_i, rd_en_i, rd_sel_i,
      input  rd_data_o, rd_valid_o, running_o, done_o
   );

   modport slave (
      input  start_i, stall_i, jump_i, branch_i, flush_i, wb_valid_i,
             snap_i, rd_en_i, rd_sel_i,
      output rd_data_o, rd_valid_o, running_o, done_o
   );
endinterface

// File: rtl/pipeline_perf_counter.sv
// Saturating pipeline event counters (cycles, data stalls, branch flushes, retired) with
// shadow snapshot, 1-cycle readout and a run-length limit FSM.
module pipeline_perf_counter #(
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 70
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   pipeline_perf_counter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   localparam int SEL_CYC = 0;
   localparam int SEL_STL = 1;
   localparam int SEL_FLS = 2;
   localparam int SEL_RET = 3;

   // A limit that cannot be represented in CNT_W bits is never reached.
   localparam bit               LIMIT_EN = (MAX_CYCLES > 0) && ($clog2(MAX_CYCLES + 1) <= CNT_W);
   localparam logic [CNT_W-1:0] LIMIT    = LIMIT_EN ? CNT_W'(MAX_CYCLES) : '0;

   state_e                     state_q, state_d;
   logic [3:0][CNT_W-1:0]      cnt_q, cnt_d;
   logic [3:0][CNT_W-1:0]      shadow_q, shadow_d;
   logic [CNT_W-1:0]           rd_data_q, rd_data_d;
   logic                       rd_valid_q, rd_valid_d;
   logic                       running_q, running_d;
   logic                       done_q, done_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = bus.rd_en_i;

      // Read sees the shadow as it was before any same-edge snapshot.
      if (bus.rd_en_i)
         rd_data_d = shadow_q[bus.rd_sel_i];

      if (bus.snap_i && (state_q != IDLE))
         shadow_d = cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.start_i)
               state_d = RUN;
         end
         RUN: begin
            if (bus.start_i) begin
               cnt_d[SEL_CYC] = sat_inc(cnt_q[SEL_CYC], 1'b1);
               cnt_d[SEL_STL] = sat_inc(cnt_q[SEL_STL], bus.stall_i & ~bus.jump_i & ~bus.branch_i);
               cnt_d[SEL_FLS] = sat_inc(cnt_q[SEL_FLS], bus.flush_i == 2'b01);
               cnt_d[SEL_RET] = sat_inc(cnt_q[SEL_RET], bus.wb_valid_i);
               if (LIMIT_EN && (cnt_d[SEL_CYC] == LIMIT))
                  state_d = DONE;
            end
         end
         default: ;
      endcase

      running_d = (state_d == RUN);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shadow_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         running_q  <= running_d;
         done_q     <= done_d;
      end
   end

   assign bus.rd_data_o  = rd_data_q;
   assign bus.rd_valid_o = rd_valid_q;
   assign bus.running_o  = running_q;
   assign bus.done_o     = done_q;
endmodule

// File: tb/tb_pipeline_perf_counter.sv
// Directed bench for pipeline_perf_counter: two instances (32-bit/limit 70 and 4-bit/no limit)
// share stimulus and are compared every cycle against a count-based reference model.
module tb_pipeline_perf_counter;
   localparam int ST_IDLE = 0;
   localparam int ST_RUN  = 1;
   localparam int ST_DONE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipeline_perf_counter_if #(.CNT_W(32)) if0 ();
   pipeline_perf_counter_if #(.CNT_W(4))  if1 ();

   assign if1.start_i    = if0.start_i;
   assign if1.stall_i    = if0.stall_i;
   assign if1.jump_i     = if0.jump_i;
   assign if1.branch_i   = if0.branch_i;
   assign if1.flush_i    = if0.flush_i;
   assign if1.wb_valid_i = if0.wb_valid_i;
   assign if1.snap_i     = if0.snap_i;
   assign if1.rd_en_i    = if0.rd_en_i;
   assign if1.rd_sel_i   = if0.rd_sel_i;

   pipeline_perf_counter #(.CNT_W(32), .MAX_CYCLES(70)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
   pipeline_perf_counter #(.CNT_W(4),  .MAX_CYCLES(0))  dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain event counts capped at each instance's maximum value.
   longint lim [2] = '{64'hFFFF_FFFF, 64'd15};
   longint maxc[2] = '{64'd70, 64'd0};
   longint m_cnt[2][4];
   longint m_sh [2][4];
   longint m_rd [2];
   bit     m_rv [2];
   int     m_st [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            for (int k = 0; k < 4; k++) begin
               m_cnt[d][k] = 0;
               m_sh[d][k]  = 0;
            end
            m_rd[d] = 0;
            m_rv[d] = 1'b0;
            m_st[d] = ST_IDLE;
         end else begin
            bit ev[4];
            m_rv[d] = if0.rd_en_i;
            if (if0.rd_en_i) m_rd[d] = m_sh[d][if0.rd_sel_i];
            if (m_st[d] != ST_IDLE && if0.snap_i)
               for (int k = 0; k < 4; k++) m_sh[d][k] = m_cnt[d][k];
            if (m_st[d] == ST_IDLE && if0.start_i) begin
               m_st[d] = ST_RUN;
            end else if (m_st[d] == ST_RUN && if0.start_i) begin
               ev[0] = 1'b1;
               ev[1] = if0.stall_i && !if0.jump_i && !if0.branch_i;
               ev[2] = (if0.flush_i == 2'b01);
               ev[3] = if0.wb_valid_i;
               for (int k = 0; k < 4; k++)
                  if (ev[k] && m_cnt[d][k] < lim[d]) m_cnt[d][k] = m_cnt[d][k] + 1;
               if (maxc[d] != 0 && m_cnt[d][0] == maxc[d]) m_st[d] = ST_DONE;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("dut0_rd_valid", if0.rd_valid_o, m_rv[0]);
         chk("dut0_rd_data",  if0.rd_data_o,  m_rd[0]);
         chk("dut0_running",  if0.running_o,  m_st[0] == ST_RUN);
         chk("dut0_done",     if0.done_o,     m_st[0] == ST_DONE);
         chk("dut1_rd_valid", if1.rd_valid_o, m_rv[1]);
         chk("dut1_rd_data",  if1.rd_data_o,  m_rd[1]);
         chk("dut1_running",  if1.running_o,  m_st[1] == ST_RUN);
         chk("dut1_done",     if1.done_o,     m_st[1] == ST_DONE);
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issue a read (rd_en left high so calls chain back-to-back) and pin both instances.
   task automatic rd(input logic [1:0] sel, input longint e0, input longint e1, input string name);
      if0.rd_en_i  = 1'b1;
      if0.rd_sel_i = sel;
      tick();
      chk({name, "_v0"}, if0.rd_valid_o, 1);
      chk({name, "_d0"}, if0.rd_data_o, e0);
      chk({name, "_d1"}, if1.rd_data_o, e1);
   endtask

   task automatic snap();
      if0.snap_i = 1'b1;
      tick();
      if0.snap_i = 1'b0;
   endtask

   initial begin
      if0.start_i = 0; if0.stall_i = 0; if0.jump_i = 0; if0.branch_i = 0;
      if0.flush_i = 2'b00; if0.wb_valid_i = 0; if0.snap_i = 0; if0.rd_en_i = 0; if0.rd_sel_i = 0;

      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_rd_valid", if0.rd_valid_o, 0);
      chk("rst_rd_data",  if0.rd_data_o, 0);
      chk("rst_running",  if0.running_o, 0);
      chk("rst_done",     if0.done_o, 0);
      rst = 1'b0;

      // T1: 10 quiet counting edges
      if0.start_i = 1; tick();
      chk("t1_running", if0.running_o, 1);
      tick(10);
      if0.start_i = 0;
      snap();
      rd(2'd0, 10, 10, "t1_cyc");
      if0.rd_en_i = 0; tick();
      chk("t1_valid_drop", if0.rd_valid_o, 0);
      chk("t1_data_hold",  if0.rd_data_o, 10);

      // T2: only stalls without jump/branch count
      if0.start_i = 1; if0.stall_i = 1;
      if0.jump_i = 1; tick(3);
      if0.jump_i = 0; tick(4);
      if0.branch_i = 1; tick(2);
      if0.branch_i = 0; if0.stall_i = 0; if0.start_i = 0;
      snap();
      rd(2'd1, 4, 4, "t2_stl");
      rd(2'd0, 19, 15, "t2_cyc");
      if0.rd_en_i = 0;

      // T3: flush code qualification and retire count
      if0.start_i = 1;
      if0.flush_i = 2'b01; tick(2);
      if0.flush_i = 2'b10; tick(3);
      if0.flush_i = 2'b11; tick(1);
      if0.flush_i = 2'b00;
      if0.wb_valid_i = 1; tick(5);
      if0.wb_valid_i = 0; if0.start_i = 0;
      snap();
      rd(2'd2, 2, 2, "t3_fls");
      rd(2'd3, 5, 5, "t3_ret");
      rd(2'd0, 30, 15, "t3_cyc");
      if0.rd_en_i = 0;

      // T4: run-length limit with stall held
      rst = 1; tick(); rst = 0;
      if0.start_i = 1; tick();
      if0.stall_i = 1; tick(69);
      chk("t4_done_69", if0.done_o, 0);
      tick();
      chk("t4_done_70", if0.done_o, 1);
      chk("t4_run_70",  if0.running_o, 0);
      tick(10);
      if0.stall_i = 0; if0.start_i = 0;
      snap();
      rd(2'd0, 70, 15, "t4_cyc");
      rd(2'd1, 70, 15, "t4_stl");
      if0.rd_en_i = 0;

      // T5: 4-bit instance saturates, never done
      rst = 1; tick(); rst = 0;
      if0.start_i = 1; tick();
      if0.stall_i = 1; tick(20);
      if0.stall_i = 0; if0.start_i = 0;
      snap();
      rd(2'd1, 20, 15, "t5_stl");
      rd(2'd0, 20, 15, "t5_cyc");
      if0.rd_en_i = 0;
      chk("t5_done1", if1.done_o, 0);
      chk("t5_run1",  if1.running_o, 1);

      // T6: reset mid-run and mid-read, then snapshot/read ordering
      rst = 1; tick(); rst = 0;
      if0.start_i = 1; tick();
      if0.stall_i = 1; tick(29);
      rst = 1; if0.rd_en_i = 1; if0.rd_sel_i = 2'd1; tick();
      chk("t6_rst_valid", if0.rd_valid_o, 0);
      chk("t6_rst_data",  if0.rd_data_o, 0);
      chk("t6_rst_run",   if0.running_o, 0);
      chk("t6_rst_done",  if0.done_o, 0);
      rst = 0; if0.rd_en_i = 0; if0.start_i = 0; if0.stall_i = 0; tick();
      chk("t6_idle", if0.running_o, 0);
      snap();
      if0.start_i = 1; tick();
      tick(5);
      if0.start_i = 0;
      snap();
      if0.start_i = 1; tick(3);
      if0.start_i = 0;
      if0.snap_i = 1;
      rd(2'd0, 5, 5, "t6_pre_snap");
      if0.snap_i = 0;
      rd(2'd0, 8, 8, "t6_post_snap");
      if0.rd_en_i = 0;
      tick(2);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
